// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative Booth multiplier.
package mult_pkg;

  // RV64M multiply operations; encodings 5..7 are folded onto OpMul at accept.
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpMulw   = 3'd4
  } mul_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mult_state_t;

  // Operand width after extension: W+2 keeps unsigned W-bit values positive and the
  // radix-4 digit count integral.
  function automatic int unsigned exten_w(input int unsigned w);
    return w + 2;
  endfunction

endpackage

// File: rtl/mult_booth_digit.sv
// One radix-4 Booth digit: recodes three multiplier bits into a 0/+-x/+-2x partial
// product, sign-extended to twice the operand width. Shift is applied by the parent.
module mult_booth_digit
  import mult_pkg::*;
#(
  parameter int unsigned EW = 66
) (
  input  logic [2:0]      y3_i,
  input  logic [EW-1:0]   x_i,
  output logic [2*EW-1:0] pp_o
);

  logic [2*EW-1:0] x_ext;
  assign x_ext = {{EW{x_i[EW-1]}}, x_i};

  // Booth recoding of {y[2j+1], y[2j], y[2j-1]}.
  always_comb begin
    pp_o = '0;
    case (y3_i)
      3'b001, 3'b010: pp_o = x_ext;
      3'b011:         pp_o = x_ext << 1;
      3'b100:         pp_o = -(x_ext << 1);
      3'b101, 3'b110: pp_o = -x_ext;
      default:        pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_booth_iter.sv
// Iterative radix-4 Booth multiplier covering MUL/MULH/MULHSU/MULHU/MULW.
// DPC Booth digits are retired per BUSY cycle; the result is registered on the last one.
module mult_booth_iter
  import mult_pkg::*;
#(
  parameter int unsigned W   = 64,
  parameter int unsigned DPC = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_res
);

  localparam int unsigned EW   = exten_w(W);
  localparam int unsigned N    = EW / 2;
  localparam int unsigned ITER = (N + DPC - 1) / DPC;
  localparam int unsigned YW   = 2 * DPC * ITER;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned AW   = 2 * EW;

  if (!(W == 32 || W == 64)) begin : g_bad_w
    $error("mult_booth_iter: W must be 32 or 64");
  end
  if (DPC < 1 || DPC > N) begin : g_bad_dpc
    $error("mult_booth_iter: DPC must lie in 1..(W+2)/2");
  end

  mult_state_t   state_q;
  mul_op_t       op_q;
  logic [EW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          y_prev_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] acc_q;
  logic [W-1:0]  res_q;

  mul_op_t       op_in;
  logic [EW-1:0] x_ext;
  logic [EW-1:0] y_ext;
  logic [YW-1:0] y_pad;
  logic [YW-1:0] y_shift;
  logic [2*DPC:0] win;
  logic [AW-1:0] pp [DPC];
  logic [AW-1:0] acc_sum;
  logic [W-1:0]  res_sel;

  // Operand decode and extension for the accept edge.
  always_comb begin
    op_in = (i_op > 3'd4) ? OpMul : mul_op_t'(i_op);
    x_ext = EW'(i_x);
    y_ext = EW'(i_y);
    unique case (op_in)
      OpMulw: begin
        x_ext = EW'($signed(i_x[31:0]));
        y_ext = EW'($signed(i_y[31:0]));
      end
      OpMulh: begin
        x_ext = EW'($signed(i_x));
        y_ext = EW'($signed(i_y));
      end
      OpMulhsu: x_ext = EW'($signed(i_x));
      default: ;
    endcase
    y_pad = YW'($signed(y_ext));
  end

  // Multiplier window for this cycle; bit 0 is the bit just below the current digit group.
  assign win     = {y_q[2*DPC-1:0], y_prev_q};
  assign y_shift = YW'($signed(y_q) >>> (2 * DPC));

  for (genvar k = 0; k < DPC; k++) begin : g_digit
    mult_booth_digit #(
      .EW (EW)
    ) u_digit (
      .y3_i (win[2*k+2:2*k]),
      .x_i  (x_q),
      .pp_o (pp[k])
    );
  end

  // Accumulate this cycle's partial products at their absolute bit positions.
  always_comb begin
    int unsigned shamt;
    acc_sum = acc_q;
    for (int unsigned k = 0; k < DPC; k++) begin
      shamt   = 2 * (32'(cnt_q) * DPC + k);
      acc_sum = acc_sum + (pp[k] << shamt);
    end
  end

  // Result selection from the final accumulator value.
  always_comb begin
    unique case (op_q)
      OpMulh, OpMulhsu, OpMulhu: res_sel = acc_sum[2*W-1:W];
      OpMulw:                    res_sel = W'($signed(acc_sum[31:0]));
      default:                   res_sel = acc_sum[W-1:0];
    endcase
  end

  // FSM plus operand, counter, accumulator and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      x_q      <= '0;
      y_q      <= '0;
      y_prev_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
    end else if (i_flush) begin
      // o_res deliberately keeps its previous value.
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            state_q  <= StBusy;
            op_q     <= op_in;
            x_q      <= x_ext;
            y_q      <= y_pad;
            y_prev_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
          end
        end
        StBusy: begin
          acc_q    <= acc_sum;
          y_q      <= y_shift;
          y_prev_q <= y_q[2*DPC-1];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_q <= StDone;
            res_q   <= res_sel;
          end
        end
        StDone: begin
          if (i_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = (state_q == StDone);
  assign o_res   = res_q;

endmodule

// File: tb/tb_mult_booth_iter.sv
// Directed bench for mult_booth_iter: three instances (DPC=1, 4, 33) share operands,
// each with its own handshake/flush controls.
module tb_mult_booth_iter;

  logic        clk;
  logic        rst;
  logic [2:0]  op_r;
  logic [63:0] x_r;
  logic [63:0] y_r;
  logic [2:0]  vin;
  logic [2:0]  fin;
  logic [2:0]  rin;
  wire  [2:0]  ov;
  wire  [2:0]  ordy;
  wire  [63:0] res [3];

  int n_total = 0;
  int n_bad   = 0;

  mult_booth_iter #(.W(64), .DPC(1)) u_dut_d1 (
    .i_clk (clk), .i_rst (rst), .i_flush (fin[0]), .i_valid (vin[0]), .o_ready (ordy[0]),
    .i_op (op_r), .i_x (x_r), .i_y (y_r), .o_valid (ov[0]), .i_ready (rin[0]), .o_res (res[0])
  );
  mult_booth_iter #(.W(64), .DPC(4)) u_dut_d4 (
    .i_clk (clk), .i_rst (rst), .i_flush (fin[1]), .i_valid (vin[1]), .o_ready (ordy[1]),
    .i_op (op_r), .i_x (x_r), .i_y (y_r), .o_valid (ov[1]), .i_ready (rin[1]), .o_res (res[1])
  );
  mult_booth_iter #(.W(64), .DPC(33)) u_dut_d33 (
    .i_clk (clk), .i_rst (rst), .i_flush (fin[2]), .i_valid (vin[2]), .o_ready (ordy[2]),
    .i_op (op_r), .i_x (x_r), .i_y (y_r), .o_valid (ov[2]), .i_ready (rin[2]), .o_res (res[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent 128-bit reference.
  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  t;
    case (op)
      3'd1: p = 128'($signed(a)) * 128'($signed(b));
      3'd2: p = 128'($signed(a)) * {64'd0, b};
      3'd3: p = {64'd0, a} * {64'd0, b};
      3'd4: begin
        t = a[31:0] * b[31:0];
        p = {64'd0, {32{t[31]}}, t};
      end
      default: p = {64'd0, a * b};
    endcase
    return (op == 3'd1 || op == 3'd2 || op == 3'd3) ? p[127:64] : p[63:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on instance d; checks latency (accept edge counted as 1) and result.
  task automatic run_op(input int d, input string tag, input logic [2:0] op,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!ordy[d] && n < 100) begin
      tick();
      n++;
    end
    op_r   = op;
    x_r    = x;
    y_r    = y;
    vin[d] = 1'b1;
    tick();
    vin[d] = 1'b0;
    // Operands must be ignored after the accept edge.
    op_r = 3'd3;
    x_r  = ~x;
    y_r  = {$urandom, $urandom};
    lat  = 1;
    while (!ov[d] && lat < 80) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, res[d], exp);
    if (rin[d]) begin
      tick();
      check({tag, "_rdy"}, 64'(ordy[d]), 64'd1);
    end
  endtask

  initial begin
    int seen;
    int unstable;
    logic [2:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;

    rst  = 1'b1;
    vin  = '0;
    fin  = '0;
    rin  = 3'b111;
    op_r = '0;
    x_r  = '0;
    y_r  = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_ready", 64'(ordy[0]), 64'd1);
    check("rst_valid", 64'(ov[0]), 64'd0);
    check("rst_res", res[0], 64'd0);

    run_op(0, "mul_3x5", 3'd0, 64'd3, 64'd5, 64'd15, 34);
    run_op(0, "mulh_m1", 3'd1, '1, '1, 64'd0, 34);
    run_op(0, "mulhsu_m1", 3'd2, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op(0, "mulhu_max", 3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run_op(0, "mulw", 3'd4, 64'h1_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run_op(0, "mul_min", 3'd0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 34);
    run_op(0, "mulh_min", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 34);
    run_op(0, "mulh_zero", 3'd1, 64'd0, 64'hDEAD_BEEF_0000_1234, 64'd0, 34);
    run_op(0, "op7_as_mul", 3'd7, 64'd6, 64'd7, 64'd42, 34);

    // Flush at BUSY cycle 10, with a competing request.
    run_op(0, "pre_flush", 3'd0, 64'd10, 64'd11, 64'd110, 34);
    op_r   = 3'd0;
    x_r    = 64'd123;
    y_r    = 64'd456;
    vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    repeat (9) tick();
    fin[0] = 1'b1;
    vin[0] = 1'b1;
    tick();
    fin[0] = 1'b0;
    vin[0] = 1'b0;
    check("flush_rdy", 64'(ordy[0]), 64'd1);
    check("flush_valid", 64'(ov[0]), 64'd0);
    check("flush_res_kept", res[0], 64'd110);
    seen = 0;
    repeat (40) begin
      tick();
      if (ov[0]) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    run_op(0, "post_flush", 3'd0, 64'd7, 64'd6, 64'd42, 34);

    // Backpressure in DONE for 20 cycles.
    rin[0] = 1'b0;
    run_op(0, "bp", 3'd0, 64'd1000, 64'd1000, 64'd1_000_000, 34);
    unstable = 0;
    repeat (20) begin
      tick();
      if (!ov[0] || ordy[0] || res[0] !== 64'd1_000_000) unstable++;
    end
    check("bp_stable", 64'(unstable), 64'd0);
    rin[0] = 1'b1;
    tick();
    check("bp_release_rdy", 64'(ordy[0]), 64'd1);
    check("bp_release_valid", 64'(ov[0]), 64'd0);

    // Flush in DONE beats a held result.
    rin[0] = 1'b0;
    run_op(0, "done_flush", 3'd3, 64'd2, '1, 64'd1, 34);
    fin[0] = 1'b1;
    rin[0] = 1'b1;
    tick();
    fin[0] = 1'b0;
    check("done_flush_valid", 64'(ov[0]), 64'd0);
    check("done_flush_rdy", 64'(ordy[0]), 64'd1);
    check("done_flush_res", res[0], 64'd1);

    // Reset in the middle of an op.
    op_r   = 3'd0;
    x_r    = 64'd9;
    y_r    = 64'd9;
    vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rdy", 64'(ordy[0]), 64'd1);
    check("midrst_res", res[0], 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (ov[0]) seen++;
    end
    check("midrst_no_result", 64'(seen), 64'd0);

    // Wider DPC instances: boundary vectors, then reference-checked operands.
    run_op(1, "d4_mulhu", 3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 10);
    run_op(2, "d33_mulhu", 3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    run_op(1, "d4_mulh_min", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 10);
    run_op(2, "d33_mulhsu", 3'd2, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_op(2, "d33_mulw", 3'd4, 64'h1_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      run_op(1, "d4_rand", rop, ra, rb, ref_mul(rop, ra, rb), 10);
      run_op(2, "d33_rand", rop, ra, rb, ref_mul(rop, ra, rb), 2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
